// File: rtl/eth_rx_packet_fifo.sv
// Store-and-forward packet FIFO behind the Ethernet RX parser.
// A packet becomes readable only once its tlast beat is written; an overflowing packet is dropped whole.
module eth_rx_packet_fifo #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [15:0]             drop_count
);

  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned PTR_WIDTH  = ADDR_WIDTH + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
  } beat_t;

  typedef enum logic [0:0] {
    WRITE = 1'b0,
    DROP  = 1'b1
  } wr_state_t;

  wr_state_t            state;
  beat_t                mem [DEPTH];
  beat_t                wr_beat;
  beat_t                rd_beat;
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] wr_commit;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [PTR_WIDTH-1:0] wr_ptr_nxt;
  logic [PTR_WIDTH-1:0] used;
  logic                 full;
  logic                 s_accept;
  logic                 mem_we;
  logic                 rd_load;

  // Upstream is never throttled; only reset holds it off.
  assign s_axis_tready = ~rst;

  assign s_accept   = s_axis_tvalid & s_axis_tready;
  assign used       = wr_ptr - rd_ptr;
  assign full       = (used == PTR_WIDTH'(DEPTH));
  assign wr_ptr_nxt = wr_ptr + PTR_WIDTH'(1);
  assign mem_we     = s_accept & (state == WRITE) & ~full;
  assign wr_beat    = '{data: s_axis_tdata, keep: s_axis_tkeep, last: s_axis_tlast};
  assign rd_beat    = mem[rd_ptr[ADDR_WIDTH-1:0]];
  // Only committed entries are visible to the reader.
  assign rd_load    = (rd_ptr != wr_commit) & (~m_axis_tvalid | m_axis_tready);

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_beat;
    end
  end

  // Write FSM, commit/drop bookkeeping and registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WRITE;
      wr_ptr        <= '0;
      wr_commit     <= '0;
      rd_ptr        <= '0;
      drop_count    <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      case (state)
        WRITE: begin
          if (s_accept) begin
            if (!full) begin
              wr_ptr <= wr_ptr_nxt;
              if (s_axis_tlast) begin
                wr_commit <= wr_ptr_nxt;
              end
            end else begin
              // Rewind to the last packet boundary so the partial packet vanishes.
              wr_ptr <= wr_commit;
              if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
              end
              if (!s_axis_tlast) begin
                state <= DROP;
              end
            end
          end
        end
        DROP: begin
          if (s_accept && s_axis_tlast) begin
            state <= WRITE;
          end
        end
        default: state <= WRITE;
      endcase

      if (rd_load) begin
        m_axis_tdata  <= rd_beat.data;
        m_axis_tkeep  <= rd_beat.keep;
        m_axis_tlast  <= rd_beat.last;
        m_axis_tvalid <= 1'b1;
        rd_ptr        <= rd_ptr + PTR_WIDTH'(1);
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_packet_fifo.sv
// Bench for eth_rx_packet_fifo (DEPTH=8 build): scoreboard of surviving beats plus directed corner cases.
module tb_eth_rx_packet_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_data;
  logic [7:0]  s_keep;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic [63:0] m_data;
  logic [7:0]  m_keep;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [15:0] drop_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [63:0] exp_data;
    logic [7:0]  exp_keep;
    logic        exp_last;
  } vec_t;

  beat_t sb[$];
  vec_t  vecs[6];

  eth_rx_packet_fifo #(
    .DATA_WIDTH(64),
    .DEPTH(8),
    .ADDR_WIDTH(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_data),
    .s_axis_tkeep (s_keep),
    .s_axis_tvalid(s_valid),
    .s_axis_tready(s_ready),
    .s_axis_tlast (s_last),
    .m_axis_tdata (m_data),
    .m_axis_tkeep (m_keep),
    .m_axis_tvalid(m_valid),
    .m_axis_tready(m_ready),
    .m_axis_tlast (m_last),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  // Output monitor: a beat transfers on the next posedge when valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat actual=%h/%h/%b required=none", m_data, m_keep, m_last);
      end else begin
        beat_t e;
        e = sb.pop_front();
        if (m_data !== e.data || m_keep !== e.keep || m_last !== e.last) begin
          bad++;
          $display("FAIL sb_beat actual=%h/%h/%b required=%h/%h/%b",
                   m_data, m_keep, m_last, e.data, e.keep, e.last);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l, input bit push);
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    s_valid = 1'b1;
    if (push) sb.push_back('{d, k, l});
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    m_ready = 1'b1;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 64'(sb.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check({name, "_idle"}, 64'(m_valid), 64'd0);
  endtask

  initial begin
    vecs[0] = '{64'h1111_0000_0000_0001, 8'h01, 1'b1, 64'h1111_0000_0000_0001, 8'h01, 1'b1};
    vecs[1] = '{64'h2222_0000_0000_0001, 8'hFF, 1'b0, 64'h2222_0000_0000_0001, 8'hFF, 1'b0};
    vecs[2] = '{64'h2222_0000_0000_0002, 8'h0F, 1'b1, 64'h2222_0000_0000_0002, 8'h0F, 1'b1};
    vecs[3] = '{64'h3333_0000_0000_0001, 8'hFF, 1'b0, 64'h3333_0000_0000_0001, 8'hFF, 1'b0};
    vecs[4] = '{64'h3333_0000_0000_0002, 8'hFF, 1'b0, 64'h3333_0000_0000_0002, 8'hFF, 1'b0};
    vecs[5] = '{64'h3333_0000_0000_0003, 8'h80, 1'b1, 64'h3333_0000_0000_0003, 8'h80, 1'b1};

    rst = 1'b1; s_data = '0; s_keep = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("s_ready_out_of_rst", 64'(s_ready), 64'd1);

    // T1: single-beat packet, one cycle of latency.
    m_ready = 1'b1;
    send(64'hAABBCCDDEEFF0011, 8'hFF, 1'b1, 1'b1);
    check("t1_valid_at_tlast", 64'(m_valid), 64'd0);
    @(posedge clk);
    #1;
    check("t1_valid", 64'(m_valid), 64'd1);
    check("t1_data", m_data, 64'hAABBCCDDEEFF0011);
    check("t1_keep", 64'(m_keep), 64'hFF);
    check("t1_last", 64'(m_last), 64'd1);
    check("t1_drop", 64'(drop_count), 64'd0);
    drain("t1_drain");

    // Table of beats with assorted tkeep patterns, back to back.
    for (int i = 0; i < 6; i++) begin
      s_data  = vecs[i].data;
      s_keep  = vecs[i].keep;
      s_last  = vecs[i].last;
      s_valid = 1'b1;
      sb.push_back('{vecs[i].exp_data, vecs[i].exp_keep, vecs[i].exp_last});
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
    drain("tbl_drain");

    // T2: output held off until tlast is written.
    m_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      send(b == 3 ? 64'hDEADBEEF_00000003 : {32'hAABBCCDD, 32'(b)}, 8'hFF, b == 3, 1'b1);
      check("t2_valid_before_commit", 64'(m_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    check("t2_valid_after_commit", 64'(m_valid), 64'd1);
    check("t2_first_data", m_data, 64'hAABBCCDD_00000000);
    @(posedge clk);
    #1;
    check("t2_held_data", m_data, 64'hAABBCCDD_00000000);
    drain("t2_drain");

    // T5: sparse input, toggling ready, 20 packets of 3 beats.
    m_ready = 1'b1;
    fork
      begin
        for (int p = 0; p < 20; p++) begin
          for (int b = 0; b < 3; b++) begin
            send({32'h5500_0000 + 32'(p), 32'(b)}, 8'hFF, b == 2, 1'b1);
            @(posedge clk);
            #1;
          end
        end
      end
      begin
        repeat (260) begin
          @(posedge clk);
          #1;
          m_ready = ~m_ready;
        end
      end
    join
    drain("t5_drain");
    check("t5_drop", 64'(drop_count), 64'd0);

    // T3: 10-beat packet overflows the 8-entry buffer, 2-beat packet survives.
    m_ready = 1'b0;
    for (int b = 0; b < 10; b++) send({32'h3300_000A, 32'(b)}, 8'hFF, b == 9, 1'b0);
    check("t3_s_ready", 64'(s_ready), 64'd1);
    for (int b = 0; b < 2; b++) send({32'h3300_0002, 32'(b)}, 8'hFF, b == 1, 1'b1);
    check("t3_drop", 64'(drop_count), 64'd1);
    drain("t3_drain");

    // T4: stored packet A followed by packet B that no longer fits.
    m_ready = 1'b0;
    for (int b = 0; b < 5; b++) send({32'h4400_000A, 32'(b)}, 8'h3F, b == 4, 1'b1);
    for (int b = 0; b < 5; b++) send({32'h4400_000B, 32'(b)}, 8'hFF, b == 4, 1'b0);
    check("t4_drop", 64'(drop_count), 64'd2);
    drain("t4_drain");

    // T6: reset in the middle of a packet discards it silently.
    m_ready = 1'b1;
    for (int b = 0; b < 3; b++) send({32'h6600_0006, 32'(b)}, 8'hFF, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_valid", 64'(m_valid), 64'd0);
    check("t6_drop", 64'(drop_count), 64'd0);
    check("t6_s_ready_in_rst", 64'(s_ready), 64'd0);
    rst = 1'b0;
    #1;
    send(64'hAABBCCDDEEFF0011, 8'hFF, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("t6_post_valid", 64'(m_valid), 64'd1);
    check("t6_post_data", m_data, 64'hAABBCCDDEEFF0011);
    drain("t6_drain");
    check("t6_final_drop", 64'(drop_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
